// File: rtl/receive_pixel_if.sv
// Pixel output handshake between the UART pixel receiver and the frame logic.
// The receiver (master) presents a pixel with valid_out; the sink answers with ready_in.
interface receive_pixel_if;
    logic [11:0] pixel;
    logic        valid_out;
    logic        ready_in;

    modport master (output pixel, output valid_out, input ready_in);
    modport slave  (input pixel, input valid_out, output ready_in);
endinterface

// File: rtl/receive_pixel.sv
// UART (8N1) receiver that rebuilds 12-bit pixels from a high byte {0000, hi[3:0]}
// followed by a low byte, and offers each pixel on a valid/ready handshake.
module receive_pixel #(
    parameter int CLK_FREQ     = 50_000_000,
    parameter int BAUD_RATE    = 115200,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            uart_in,
    receive_pixel_if.master pix_if,
    output logic            frame_err,
    output logic            overrun
);
    localparam int CLKS_PER_BIT   = CLK_FREQ / BAUD_RATE;
    localparam int HALF_BIT       = CLKS_PER_BIT / 2;
    localparam int TIMEOUT_CYCLES = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int CNT_W          = $clog2(CLKS_PER_BIT);
    localparam int TO_W           = $clog2(TIMEOUT_CYCLES + 1);

    // The start-detect cycle in IDLE counts as the first cycle of the half bit,
    // so the counter enters START at 1 and the mid-start sample lands HALF_BIT
    // cycles after the edge leaves the synchroniser.
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_WAIT_HIGH
    } state_t;

    logic             sync1_q, sync1_d;
    logic             rx_s_q, rx_s_d;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic             phase_lo_q, phase_lo_d;
    logic [3:0]       hi_nib_q, hi_nib_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic [11:0]      pixel_q, pixel_d;
    logic             valid_q, valid_d;
    logic             frame_err_q, frame_err_d;
    logic             overrun_q, overrun_d;
    logic             byte_done;
    logic             stop_bad;
    logic             pixel_done;

    // Bit-level receive FSM: start validation, 8 data samples, stop check.
    always_comb begin
        sync1_d   = uart_in;
        rx_s_d    = sync1_q;
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        byte_done = 1'b0;
        stop_bad  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!rx_s_q) begin
                    state_d   = ST_START;
                    clk_cnt_d = CNT_W'(1);
                    bit_cnt_d = 3'd0;
                end
            end
            ST_START: begin
                if (clk_cnt_q == HALF_LAST) begin
                    clk_cnt_d = '0;
                    state_d   = rx_s_q ? ST_IDLE : ST_DATA;
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (clk_cnt_q == BIT_LAST) begin
                    clk_cnt_d = '0;
                    shift_d   = {rx_s_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = ST_STOP;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                end
            end
            ST_STOP: begin
                if (clk_cnt_q == BIT_LAST) begin
                    clk_cnt_d = '0;
                    if (rx_s_q) begin
                        byte_done = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        stop_bad = 1'b1;
                        state_d  = ST_WAIT_HIGH;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                end
            end
            ST_WAIT_HIGH: begin
                if (rx_s_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Byte pairing: high nibble first, then the low byte; abandon on error or idle timeout.
    always_comb begin
        phase_lo_d = phase_lo_q;
        hi_nib_d   = hi_nib_q;
        to_cnt_d   = to_cnt_q;
        pixel_done = 1'b0;
        if (stop_bad) begin
            phase_lo_d = 1'b0;
            hi_nib_d   = 4'd0;
            to_cnt_d   = '0;
        end else if (byte_done) begin
            if (phase_lo_q) begin
                pixel_done = 1'b1;
                phase_lo_d = 1'b0;
            end else if (shift_q[7:4] == 4'd0) begin
                hi_nib_d   = shift_q[3:0];
                phase_lo_d = 1'b1;
                to_cnt_d   = '0;
            end
        end else if (phase_lo_q && (state_q == ST_IDLE)) begin
            if (to_cnt_q == TO_LAST) begin
                phase_lo_d = 1'b0;
                hi_nib_d   = 4'd0;
                to_cnt_d   = '0;
            end else begin
                to_cnt_d = to_cnt_q + TO_W'(1);
            end
        end
    end

    // Output holding register: load when empty or draining, otherwise drop and flag overrun.
    always_comb begin
        pixel_d     = pixel_q;
        valid_d     = valid_q && !pix_if.ready_in;
        overrun_d   = 1'b0;
        frame_err_d = stop_bad;
        if (pixel_done) begin
            if (!valid_q || pix_if.ready_in) begin
                pixel_d = {hi_nib_q, shift_q};
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    // State registers with asynchronous active-low reset; the line synchroniser idles high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q     <= 1'b1;
            rx_s_q      <= 1'b1;
            state_q     <= ST_IDLE;
            clk_cnt_q   <= '0;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'd0;
            phase_lo_q  <= 1'b0;
            hi_nib_q    <= 4'd0;
            to_cnt_q    <= '0;
            pixel_q     <= 12'd0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            rx_s_q      <= rx_s_d;
            state_q     <= state_d;
            clk_cnt_q   <= clk_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            phase_lo_q  <= phase_lo_d;
            hi_nib_q    <= hi_nib_d;
            to_cnt_q    <= to_cnt_d;
            pixel_q     <= pixel_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign pix_if.pixel     = pixel_q;
    assign pix_if.valid_out = valid_q;
    assign frame_err        = frame_err_q;
    assign overrun          = overrun_q;
endmodule

// File: tb/tb_receive_pixel.sv
// Bench for receive_pixel: directed scenarios plus random byte traffic, checked every
// cycle against a byte-level reference model of the pixel stream.
module tb_receive_pixel;
    localparam int CPB            = 10;
    localparam int LAT            = 2 + CPB / 2 + 9 * CPB;
    localparam int TIMEOUT_CYCLES = 20 * CPB;

    typedef struct {
        int         s_cyc;
        int         d_cyc;
        logic [7:0] data;
        bit         stop_ok;
    } byte_ev_t;

    logic clk = 1'b0;
    logic rst;
    logic uart_in;
    logic ready_in;
    logic frame_err;
    logic overrun;

    receive_pixel_if pix_if ();
    assign pix_if.ready_in = ready_in;

    receive_pixel #(
        .CLK_FREQ     (1000),
        .BAUD_RATE    (100),
        .TIMEOUT_BITS (20)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .uart_in   (uart_in),
        .pix_if    (pix_if),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    int vectors    = 0;
    int miscompares = 0;
    int cyc        = 0;
    bit rand_ready = 0;

    byte_ev_t   ev_q[$];
    byte_ev_t   ev;
    logic [11:0] m_pixel = 12'd0;
    bit          m_valid = 0;
    bit          m_fe = 0;
    bit          m_ov = 0;
    bit          m_phase_lo = 0;
    logic [3:0]  m_hi = 4'd0;
    int          m_hi_s = 0;

    int valid_cycles = 0;
    int last_valid_cyc = -1;
    int xfer_count = 0;
    logic [11:0] last_xfer_pixel = 12'd0;
    int fe_count = 0;
    int ov_count = 0;

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Reference model reset follows the DUT's asynchronous reset.
    always @(negedge rst) begin
        m_pixel    = 12'd0;
        m_valid    = 0;
        m_fe       = 0;
        m_ov       = 0;
        m_phase_lo = 0;
        m_hi       = 4'd0;
        ev_q.delete();
    end

    // Reference model: byte completions arrive at their stop-sample cycle and drive pairing and output.
    always @(posedge clk) begin
        bit pre_valid;
        bit xfer;
        cyc = cyc + 1;
        if (rst) begin
            pre_valid = m_valid;
            xfer      = m_valid && ready_in;
            m_fe      = 0;
            m_ov      = 0;
            if (xfer) m_valid = 0;
            if (ev_q.size() > 0 && ev_q[0].s_cyc == cyc) begin
                ev = ev_q.pop_front();
                if (!ev.stop_ok) begin
                    m_fe       = 1;
                    m_phase_lo = 0;
                end else begin
                    if (m_phase_lo && (ev.d_cyc - m_hi_s) >= TIMEOUT_CYCLES) m_phase_lo = 0;
                    if (m_phase_lo) begin
                        m_phase_lo = 0;
                        if (!pre_valid || xfer) begin
                            m_pixel = {m_hi, ev.data};
                            m_valid = 1;
                        end else begin
                            m_ov = 1;
                        end
                    end else if (ev.data[7:4] == 4'd0) begin
                        m_hi       = ev.data[3:0];
                        m_phase_lo = 1;
                        m_hi_s     = ev.s_cyc;
                    end
                end
            end
        end
    end

    // Per-cycle compare against the model plus event bookkeeping for the directed checks.
    always @(negedge clk) begin
        checkOutput("valid_out", {31'd0, pix_if.valid_out}, {31'd0, m_valid});
        checkOutput("pixel", {20'd0, pix_if.pixel}, {20'd0, m_pixel});
        checkOutput("frame_err", {31'd0, frame_err}, {31'd0, m_fe});
        checkOutput("overrun", {31'd0, overrun}, {31'd0, m_ov});
        if (pix_if.valid_out === 1'b1) begin
            valid_cycles++;
            last_valid_cyc = cyc;
            if (ready_in) begin
                xfer_count++;
                last_xfer_pixel = pix_if.pixel;
            end
        end
        if (frame_err === 1'b1) fe_count++;
        if (overrun === 1'b1) ov_count++;
    end

    // Random backpressure when enabled.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) ready_in = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: run did not finish, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic waitCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Sends one 8N1 byte starting now (just after an edge), then idles the line for gap cycles.
    task automatic applyStimulus(input logic [7:0] data, input bit stop_ok, input int gap, output int s_cyc);
        byte_ev_t e;
        e.s_cyc   = cyc + LAT;
        e.d_cyc   = cyc + 3;
        e.data    = data;
        e.stop_ok = stop_ok;
        ev_q.push_back(e);
        s_cyc = e.s_cyc;
        uart_in = 1'b0;
        waitCycles(CPB);
        for (int i = 0; i < 8; i++) begin
            uart_in = data[i];
            waitCycles(CPB);
        end
        uart_in = stop_ok;
        waitCycles(CPB);
        uart_in = 1'b1;
        waitCycles(gap);
    endtask

    initial begin
        int s;
        int vc0;
        int fe0;
        int ov0;
        int xc0;
        int r;
        int gap;
        bit ok;
        logic [7:0] d;

        rst      = 1'b0;
        uart_in  = 1'b1;
        ready_in = 1'b0;
        @(posedge clk);
        #1;
        waitCycles(3);
        checkOutput("reset pixel", {20'd0, pix_if.pixel}, 32'h0);
        checkOutput("reset valid", {31'd0, pix_if.valid_out}, 32'h0);
        rst = 1'b1;
        waitCycles(5);

        $display("[TB] nominal");
        ready_in = 1'b1;
        vc0 = valid_cycles; fe0 = fe_count; ov0 = ov_count;
        applyStimulus(8'h0A, 1, 0, s);
        applyStimulus(8'hAA, 1, 5, s);
        checkOutput("nominal pixel", {20'd0, pix_if.pixel}, 32'hAAA);
        checkOutput("nominal valid count", valid_cycles - vc0, 1);
        checkOutput("nominal valid cycle", last_valid_cyc, s);
        checkOutput("nominal frame_err count", fe_count - fe0, 0);
        checkOutput("nominal overrun count", ov_count - ov0, 0);

        $display("[TB] backpressure");
        ready_in = 1'b0;
        waitCycles(1);
        ov0 = ov_count; xc0 = xfer_count;
        applyStimulus(8'h01, 1, 0, s);
        applyStimulus(8'h23, 1, 0, s);
        applyStimulus(8'h04, 1, 0, s);
        applyStimulus(8'h56, 1, 5, s);
        checkOutput("backpressure pixel", {20'd0, pix_if.pixel}, 32'h123);
        checkOutput("backpressure valid", {31'd0, pix_if.valid_out}, 32'h1);
        checkOutput("backpressure overrun count", ov_count - ov0, 1);
        ready_in = 1'b1;
        waitCycles(3);
        checkOutput("drain valid", {31'd0, pix_if.valid_out}, 32'h0);
        checkOutput("drain transfer count", xfer_count - xc0, 1);
        checkOutput("drain transfer pixel", {20'd0, last_xfer_pixel}, 32'h123);

        $display("[TB] glitch and framing");
        vc0 = valid_cycles; fe0 = fe_count;
        uart_in = 1'b0;
        waitCycles(3);
        uart_in = 1'b1;
        waitCycles(30);
        applyStimulus(8'h0F, 0, 20, s);
        checkOutput("framing frame_err count", fe_count - fe0, 1);
        checkOutput("framing valid count", valid_cycles - vc0, 0);
        applyStimulus(8'h07, 1, 0, s);
        applyStimulus(8'h89, 1, 5, s);
        checkOutput("framing recovery pixel", {20'd0, pix_if.pixel}, 32'h789);

        $display("[TB] sync recovery");
        vc0 = valid_cycles;
        applyStimulus(8'h5A, 1, 5, s);
        applyStimulus(8'h03, 1, 0, s);
        applyStimulus(8'h21, 1, 5, s);
        checkOutput("sync pixel", {20'd0, pix_if.pixel}, 32'h321);
        checkOutput("sync valid count", valid_cycles - vc0, 1);

        $display("[TB] timeout");
        ready_in = 1'b0;
        applyStimulus(8'h0B, 1, 250, s);
        applyStimulus(8'h0F, 1, 0, s);
        applyStimulus(8'hFF, 1, 5, s);
        checkOutput("timeout pixel", {20'd0, pix_if.pixel}, 32'hFFF);
        checkOutput("timeout valid", {31'd0, pix_if.valid_out}, 32'h1);

        $display("[TB] reset mid-byte");
        uart_in = 1'b0;
        waitCycles(CPB);
        uart_in = 1'b0;
        waitCycles(25);
        #3;
        rst = 1'b0;
        #1;
        checkOutput("async reset pixel", {20'd0, pix_if.pixel}, 32'h0);
        checkOutput("async reset valid", {31'd0, pix_if.valid_out}, 32'h0);
        checkOutput("async reset frame_err", {31'd0, frame_err}, 32'h0);
        checkOutput("async reset overrun", {31'd0, overrun}, 32'h0);
        uart_in = 1'b1;
        @(posedge clk);
        #1;
        waitCycles(3);
        rst = 1'b1;
        waitCycles(5);
        ready_in = 1'b1;
        applyStimulus(8'h0C, 1, 0, s);
        applyStimulus(8'h34, 1, 5, s);
        checkOutput("post-reset pixel", {20'd0, pix_if.pixel}, 32'hC34);

        $display("[TB] random traffic");
        rand_ready = 1;
        for (int n = 0; n < 60; n++) begin
            r = int'($urandom_range(0, 1));
            d = 8'($urandom_range(0, 255));
            if (r == 0) d[7:4] = 4'd0;
            ok = ($urandom_range(0, 9) != 0);
            r = int'($urandom_range(0, 14));
            if (r == 0) gap = 300;
            else if (r < 5) gap = 0;
            else gap = int'($urandom_range(1, 40));
            if (!ok && gap < 15) gap = 15;
            applyStimulus(d, ok, gap, s);
        end
        rand_ready = 0;
        waitCycles(2);
        ready_in = 1'b1;
        waitCycles(120);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/receive_pixel.md
# receive_pixel

UART receiver that reassembles 12-bit pixels sent as two serial bytes, high byte first. It sits on the NANO-to-FPGA side of the Wi-Fi link. It converts the 8N1 serial stream back into pixel words. It presents each pixel on a valid/ready handshake to the downstream frame logic.

## Interface

Parameters:
- CLK_FREQ, 50_000_000, system clock frequency in Hz
- BAUD_RATE, 115200, serial bit rate; CLKS_PER_BIT = CLK_FREQ / BAUD_RATE (integer divide, must be ≥ 4)
- TIMEOUT_BITS, 20, idle bit-times after a high byte before the pair is abandoned

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  reset, asynchronous, active-low
- uart_in  in  1  serial line, idle high, asynchronous to clk
- ready_in  in  1  downstream ready to accept a pixel
- pixel  out  12  received pixel {hi[3:0], lo[7:0]}
- valid_out  out  1  pixel holds an unaccepted word
- frame_err  out  1  one-cycle pulse: stop bit sampled low
- overrun  out  1  one-cycle pulse: completed pixel dropped because output was still occupied

## Operation

Line synchronisation:
- uart_in passes through a 2-flop synchroniser.
- Both flops reset to 1.
- All decoding uses the second flop (rx_s).

Bit FSM (IDLE, START, DATA, STOP, WAIT_HIGH):
- IDLE: rx_s == 0 → START, clear bit counter.
- START: after CLKS_PER_BIT/2 cycles, resample rx_s. If it is 0 → DATA. If it is 1 → IDLE; this is a glitch, and no error is flagged.
- DATA: sample every CLKS_PER_BIT cycles, 8 samples, LSB first into a shift register → STOP.
- STOP: sample after CLKS_PER_BIT cycles. If rx_s == 1 → byte_done (internal one-cycle strobe), then IDLE. If rx_s == 0 → frame_err pulse, discard the byte, → WAIT_HIGH.
- WAIT_HIGH: stay until rx_s == 1, then → IDLE.

Byte assembler (phase HI/LO):
- HI phase, byte with upper nibble == 0 → latch hi[3:0], phase = LO, start the timeout counter.
- HI phase, byte with upper nibble ≠ 0 → discard silently, stay HI. This is a sync error.
- LO phase, byte → pixel complete, phase = HI.
- frame_err in either phase → phase = HI, and any latched high nibble is discarded.
- Timeout: in LO phase, if TIMEOUT_BITS × CLKS_PER_BIT cycles elapse with the FSM in IDLE since the high byte → phase = HI.

Output register:
- On pixel complete with valid_out == 0, or valid_out && ready_in in the same cycle: load pixel and set valid_out.
- On pixel complete when valid_out == 1 and ready_in == 0: drop the new pixel. pixel and valid_out are unchanged, and overrun pulses.
- valid_out clears on the cycle after valid_out && ready_in, unless a new load occurs in that same cycle.
- pixel is stable while valid_out == 1.

## Timing

Reset values:
- pixel = 0, valid_out = 0, frame_err = 0, overrun = 0.
- FSM = IDLE, phase = HI, all counters 0.

Reset mid-byte: all state returns to reset values immediately (asynchronous). The partial byte is lost. A byte whose start edge falls after reset release is received normally.

Latency:
- valid_out rises 1 cycle after the low byte's stop-bit sample.
- That sample is 2 (synchroniser) + CLKS_PER_BIT/2 + 9×CLKS_PER_BIT cycles after the low byte's start edge reaches uart_in.

Pulses:
- frame_err is registered and asserts the cycle after the failed stop sample.
- overrun is registered and asserts the cycle after the dropped completion.
- Each is high for exactly 1 cycle.

Handshake: a transfer occurs on any rising edge with valid_out && ready_in. With ready_in held at 1, valid_out is high for exactly 1 cycle per pixel.

Back-to-back bytes: no gap is required between a stop bit and the next start bit. IDLE re-arms in the cycle after the stop sample.

## Test plan

All scenarios use CLK_FREQ=1000, BAUD_RATE=100, so CLKS_PER_BIT=10.
- Nominal: ready_in=1, send bytes 0x0A then 0xAA → pixel=0xAAA. valid_out is high 1 cycle, 1 cycle after the second stop sample. No frame_err or overrun.
- Backpressure/overrun: ready_in=0, send 0x01,0x23 then 0x04,0x56 → pixel stays 0x123 with valid_out high, and overrun pulses once. Then raise ready_in → one transfer of 0x123, after which valid_out = 0.
- Framing error and glitch: apply a 3-cycle low glitch → nothing happens. Send 0x0F with stop bit = 0 → frame_err pulse, no valid. Then send 0x07,0x89 → pixel=0x789.
- Sync recovery: send 0x5A → discarded, no output. Then send 0x03,0x21 → pixel=0x321.
- Timeout: send 0x0B, then idle 250 cycles. Then send 0x0F,0xFF → pixel=0xFFF (not 0xBxx).
- Reset mid-byte: assert rst during DATA of a high byte → all outputs 0 immediately. After release, send 0x0C,0x34 → pixel=0xC34.
